// File: rtl/wrr_cfg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wrr_cfg_arbiter
// Purpose  : Owner of the WRR rank-calculator config channel. After reset,
//            or on init_start, it sweeps DEFAULT_WEIGHT into every weight
//            entry. Otherwise it serialises host register-bridge reads and
//            writes, with one command outstanding at a time.
// Revision : 1.0 - initial release
// ============================================================================
module wrr_cfg_arbiter #(
    parameter int                         ID_WIDTH        = 8,
    parameter int                         ID_COUNTER      = 160,
    parameter int                         CPU_WRITE_WIDTH = 8,
    parameter int                         CPU_OUT_WIDTH   = 29,
    parameter logic [CPU_WRITE_WIDTH-1:0] DEFAULT_WEIGHT  = 8'd1,
    parameter int                         TIMEOUT_CYCLES  = 16
) (
    input  logic                       clk_cp,
    input  logic                       rst,
    input  logic                       host_req_valid,
    output logic                       host_req_ready,
    input  logic                       host_req_write,
    input  logic [ID_WIDTH-1:0]        host_req_index,
    input  logic [CPU_WRITE_WIDTH-1:0] host_req_wdata,
    output logic                       host_rsp_valid,
    output logic [CPU_OUT_WIDTH-1:0]   host_rsp_data,
    output logic                       host_rsp_err,
    input  logic                       init_start,
    output logic                       init_busy,
    output logic [7:0]                 init_err_cnt,
    output logic                       cfg_cpu_valid,
    output logic [ID_WIDTH-1:0]        cfg_cpu_index,
    output logic                       cfg_cpu_write_sig,
    output logic [CPU_WRITE_WIDTH-1:0] cfg_cpu_config_write,
    output logic                       cfg_cpu_read_sig,
    input  logic                       cfg_rsp_valid,
    input  logic [ID_WIDTH-1:0]        cfg_rsp_index,
    input  logic [CPU_OUT_WIDTH-1:0]   cfg_rsp_val
);

    localparam int                   c_timer_w  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ID_WIDTH-1:0]  c_last_idx = ID_WIDTH'(ID_COUNTER - 1);
    localparam logic [c_timer_w-1:0] c_timeout  = c_timer_w'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_INIT_ISSUE = 3'd0,
        S_INIT_WAIT  = 3'd1,
        S_IDLE       = 3'd2,
        S_HOST_ISSUE = 3'd3,
        S_HOST_WAIT  = 3'd4
    } state_t;

    state_t                     r_state;
    logic [ID_WIDTH-1:0]        r_sweep_idx;
    logic [c_timer_w-1:0]       r_timer;
    logic [7:0]                 r_err_cnt;
    logic                       r_busy;
    logic                       r_host_write;
    logic [ID_WIDTH-1:0]        r_host_index;
    logic [CPU_WRITE_WIDTH-1:0] r_host_wdata;
    logic                       r_cmd_valid;
    logic [ID_WIDTH-1:0]        r_cmd_index;
    logic                       r_cmd_write;
    logic                       r_cmd_read;
    logic [CPU_WRITE_WIDTH-1:0] r_cmd_wdata;
    logic                       r_rsp_valid;
    logic                       r_rsp_err;
    logic [CPU_OUT_WIDTH-1:0]   r_rsp_data;

    logic [ID_WIDTH-1:0]        w_tgt_index;
    logic                       w_match;
    logic [c_timer_w-1:0]       w_timer_inc;
    logic                       w_expire;
    logic                       w_bad_index;

    // The outstanding command's index: host target in HOST_WAIT, else sweep.
    assign w_tgt_index = (r_state == S_HOST_WAIT) ? r_host_index : r_sweep_idx;
    assign w_match     = cfg_rsp_valid && (cfg_rsp_index == w_tgt_index);
    // r_timer counts completed wait cycles; the current one is the expiry
    // cycle when it brings the count to TIMEOUT_CYCLES.
    assign w_timer_inc = r_timer + 1'b1;
    assign w_expire    = (w_timer_inc == c_timeout);
    assign w_bad_index = int'(host_req_index) >= ID_COUNTER;

    // Ready is the IDLE-state register gated by init_start, so a request is
    // never seen as accepted in the cycle the sweep request takes priority.
    assign host_req_ready       = (r_state == S_IDLE) && !init_start;
    assign host_rsp_valid       = r_rsp_valid;
    assign host_rsp_data        = r_rsp_data;
    assign host_rsp_err         = r_rsp_err;
    assign init_busy            = r_busy;
    assign init_err_cnt         = r_err_cnt;
    assign cfg_cpu_valid        = r_cmd_valid;
    assign cfg_cpu_index        = r_cmd_index;
    assign cfg_cpu_write_sig    = r_cmd_write;
    assign cfg_cpu_config_write = r_cmd_wdata;
    assign cfg_cpu_read_sig     = r_cmd_read;

    // Control FSM: command strobes and host responses are single-cycle pulses.
    always_ff @(posedge clk_cp) begin
        if (!rst) begin
            r_state      <= S_INIT_ISSUE;
            r_sweep_idx  <= '0;
            r_timer      <= '0;
            r_err_cnt    <= '0;
            r_busy       <= 1'b0;
            r_host_write <= 1'b0;
            r_host_index <= '0;
            r_host_wdata <= '0;
            r_cmd_valid  <= 1'b0;
            r_cmd_index  <= '0;
            r_cmd_write  <= 1'b0;
            r_cmd_read   <= 1'b0;
            r_cmd_wdata  <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_data   <= '0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_cmd_index <= '0;
            r_cmd_write <= 1'b0;
            r_cmd_read  <= 1'b0;
            r_cmd_wdata <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
            case (r_state)
                S_INIT_ISSUE: begin
                    r_cmd_valid <= 1'b1;
                    r_cmd_write <= 1'b1;
                    r_cmd_index <= r_sweep_idx;
                    r_cmd_wdata <= DEFAULT_WEIGHT;
                    r_timer     <= '0;
                    r_busy      <= 1'b1;
                    r_state     <= S_INIT_WAIT;
                end
                S_INIT_WAIT: begin
                    if (w_match || w_expire) begin
                        if (!w_match && (r_err_cnt != 8'hFF)) begin
                            r_err_cnt <= r_err_cnt + 8'd1;
                        end
                        if (r_sweep_idx == c_last_idx) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_sweep_idx <= r_sweep_idx + 1'b1;
                            r_state     <= S_INIT_ISSUE;
                        end
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                S_IDLE: begin
                    if (init_start) begin
                        r_sweep_idx <= '0;
                        r_err_cnt   <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= S_INIT_ISSUE;
                    end else if (host_req_valid) begin
                        if (w_bad_index) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end else begin
                            r_host_write <= host_req_write;
                            r_host_index <= host_req_index;
                            r_host_wdata <= host_req_wdata;
                            r_state      <= S_HOST_ISSUE;
                        end
                    end
                end
                S_HOST_ISSUE: begin
                    r_cmd_valid <= 1'b1;
                    r_cmd_index <= r_host_index;
                    r_cmd_write <= r_host_write;
                    r_cmd_read  <= !r_host_write;
                    r_cmd_wdata <= r_host_write ? r_host_wdata : '0;
                    r_timer     <= '0;
                    r_state     <= S_HOST_WAIT;
                end
                S_HOST_WAIT: begin
                    if (w_match) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= cfg_rsp_val;
                        r_state     <= S_IDLE;
                    end else if (w_expire) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
